// File: rtl/issue_scoreboard.sv
// Issue controller between decoder output registers and execute: RAW scoreboard,
// stream-tag ownership and post-jump flush window.
// issue/stall/kill are combinational on this cycle's inputs; scoreboard and tag are registered.

package issue_pkg;
  typedef enum logic [2:0] {
    R_type = 3'd0,
    I_type = 3'd1,
    S_type = 3'd2,
    B_type = 3'd3,
    U_type = 3'd4,
    J_type = 3'd5
  } fmts;

  typedef enum logic [4:0] {
    NOP     = 5'd0,
    INVALID = 5'd1,
    FENCE   = 5'd2,
    ADD     = 5'd3,
    SUB     = 5'd4,
    ADDI    = 5'd5,
    LW      = 5'd6,
    SW      = 5'd7,
    BEQ     = 5'd8,
    LUI     = 5'd9,
    AUIPC   = 5'd10,
    JAL     = 5'd11,
    JALR    = 5'd12
  } instruction_type;
endpackage

module issue_scoreboard
  import issue_pkg::*;
#(
  parameter int FLUSH_CYC = 2,
  parameter int TAG_W     = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             dec_valid,
  input  logic [4:0]       dec_regA,
  input  logic [4:0]       dec_regB,
  input  logic [4:0]       dec_regD,
  input  fmts              dec_fmt,
  input  instruction_type  dec_i,
  input  logic [TAG_W-1:0] dec_tag,
  input  logic             ex_ready,
  input  logic             wb_valid,
  input  logic [4:0]       wb_reg,
  input  logic             jump_taken,
  output logic             issue_valid,
  output logic             stall,
  output logic             kill,
  output logic [TAG_W-1:0] curr_tag,
  output logic [31:0]      busy_mask
);

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

  state_t      state;
  logic [2:0]  flush_cnt;

  logic        uses_a;
  logic        uses_b;
  logic        writes_d;
  logic [31:0] wb_onehot;
  logic [31:0] eff_busy;
  logic        hazard;
  logic        match;
  logic [31:0] set_mask;

  // Operand usage from format / opcode; x0 is never tracked as a destination.
  always_comb begin
    uses_a   = !(dec_fmt == U_type || dec_fmt == J_type);
    uses_b   = (dec_fmt == R_type || dec_fmt == S_type || dec_fmt == B_type);
    writes_d = !(dec_fmt == S_type || dec_fmt == B_type) && (dec_regD != 5'd0) &&
               !(dec_i == NOP || dec_i == INVALID || dec_i == FENCE);
  end

  // Same-cycle writeback is visible to the hazard check (regbank writes through).
  always_comb begin
    wb_onehot = wb_valid ? (32'd1 << wb_reg) : 32'd0;
    eff_busy  = busy_mask & ~wb_onehot;
    hazard    = (uses_a & eff_busy[dec_regA]) | (uses_b & eff_busy[dec_regB]);
    match     = (dec_tag == curr_tag);
  end

  // Issue / stall / kill decisions for the instruction currently in decode.
  always_comb begin
    issue_valid = 1'b0;
    stall       = 1'b0;
    kill        = 1'b0;
    if (!reset) begin
      if (state == RUN) begin
        kill        = dec_valid & ~match;
        issue_valid = dec_valid & match & ~hazard & ex_ready & ~jump_taken;
        stall       = dec_valid & match & (hazard | ~ex_ready);
      end else begin
        kill        = dec_valid;
      end
    end
  end

  // Destination bit to mark busy; takes priority over a same-cycle release.
  always_comb begin
    set_mask = (issue_valid & writes_d) ? (32'd1 << dec_regD) : 32'd0;
  end

  // Scoreboard register; bit 0 is held clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_mask <= 32'd0;
    end else begin
      busy_mask <= ((busy_mask & ~wb_onehot) | set_mask) & 32'hFFFF_FFFE;
    end
  end

  // Stream tag and flush-window state machine; a jump always restarts the window.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RUN;
      flush_cnt <= 3'd0;
      curr_tag  <= '0;
    end else if (jump_taken) begin
      state     <= FLUSH;
      flush_cnt <= 3'(FLUSH_CYC);
      curr_tag  <= curr_tag + TAG_W'(1);
    end else if (state == FLUSH) begin
      if (flush_cnt <= 3'd1) begin
        state     <= RUN;
        flush_cnt <= 3'd0;
      end else begin
        flush_cnt <= flush_cnt - 3'd1;
      end
    end
  end

endmodule

// File: doc/issue_scoreboard.md
Name: issue_scoreboard

Overview:
Issue controller between the decoder output registers and the execute stage.
- Tracks pending destination-register writes in a 32-entry scoreboard.
- Stalls decode on RAW hazards or execute back-pressure.
- Owns the current stream tag and runs a post-jump flush window that discards wrong-path instructions.
- Replaces the unused decoder clock-enable with a real stall signal.

Parameters:
FLUSH_CYC, 2, cycles issue is blocked after a taken jump (1..7)
TAG_W, 4, stream tag width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
dec_valid  in  1  decoder output registers hold an instruction
dec_regA  in  5  rs1 from decoder
dec_regB  in  5  rs2 from decoder
dec_regD  in  5  rd from decoder
dec_fmt  in  fmts  instruction format from decoder
dec_i  in  instruction_type  decoded instruction
dec_tag  in  TAG_W  stream tag of decoded instruction
ex_ready  in  1  execute accepts an instruction this cycle
wb_valid  in  1  a previously issued writing instruction retires
wb_reg  in  5  register released by the retirement
jump_taken  in  1  execute resolved a taken branch/jump (1-cycle pulse)
issue_valid  out  1  instruction in decode is handed to execute this cycle
stall  out  1  freeze decoder and fetch registers
kill  out  1  instruction in decode is discarded (wrong tag or flush)
curr_tag  out  TAG_W  current valid stream tag, to fetch
busy_mask  out  32  scoreboard state (registered), debug/verification

Behaviour:
Reset (synchronous, active-high):
- busy_mask = 0, curr_tag = 0, state RUN, flush counter = 0.
- issue_valid, stall, kill = 0 during and after reset until inputs dictate otherwise.

Operand use:
- uses_A: fmt ∉ {U_type, J_type}.
- uses_B: fmt ∈ {R_type, S_type, B_type}.
- writes_D: fmt ∉ {S_type, B_type}, dec_regD ≠ 0, and dec_i ∉ {NOP, INVALID, FENCE}.

Effective busy and hazard:
- eff_busy[r] = busy_mask[r] & ~(wb_valid & wb_reg == r). A same-cycle writeback is visible; the regbank writes through.
- Bit 0 is never set.
- hazard = (uses_A & eff_busy[regA]) | (uses_B & eff_busy[regB]).

State machine:
- RUN:
  - match = dec_tag == curr_tag.
  - kill = dec_valid & ~match.
  - issue_valid = dec_valid & match & ~hazard & ex_ready.
  - stall = dec_valid & match & (hazard | ~ex_ready).
- FLUSH:
  - issue_valid = 0, stall = 0, kill = dec_valid.
  - Counter decrements each cycle; go to RUN the cycle after it reaches 1.
- jump_taken in any state:
  - curr_tag <= curr_tag + 1, wrapping modulo 2^TAG_W (15→0 at default).
  - Go to FLUSH with counter = FLUSH_CYC.
  - issue_valid is forced 0 that same cycle.
  - A jump_taken during FLUSH restarts the counter and increments the tag again.

Scoreboard update (registered, 1-cycle latency):
- On issue_valid & writes_D: set busy[regD].
- On wb_valid: clear busy[wb_reg].
- Same register set and cleared in the same cycle: the set wins.

Writeback contract:
- Execute guarantees exactly one wb_valid per issued writing instruction, including instructions squashed after a jump.
- A wb_valid for a non-busy register is ignored. No error is flagged.

Hazard latency:
- A dependent instruction may issue in the same cycle its producer's wb_valid is seen.
- A back-to-back dependent instruction (producer issued the previous cycle) always stalls.

Reset mid-operation:
- All scoreboard bits clear and the tag returns to 0 regardless of state.
- Upstream is required to reset in the same cycle.

Test Plan:
- Reset, then ADD x5 (R_type, regD=5) with ex_ready=1 → issue_valid=1, busy_mask=0x00000020 next cycle; following ADD x6,x5,x1 → stall=1, issue_valid=0 until wb_valid,wb_reg=5, then issue_valid=1 in that same cycle.
- LUI x0 then ADD using x0 → busy_mask stays 0, no stall; SW with regD field=7 → bit 7 not set.
- ex_ready=0 for 3 cycles with no hazard → stall=1 for 3 cycles, issue_valid rises on the cycle ex_ready=1.
- curr_tag=15, jump_taken pulse → curr_tag=0, kill=1 for 2 cycles (FLUSH_CYC=2), dec_tag=15 instruction afterward → kill=1, dec_tag=0 → issues.
- Same cycle: issue ADD x9 while wb_valid,wb_reg=9 → busy_mask[9]=1 next cycle.
- reset asserted while in FLUSH with busy_mask=0x00000F00 → next cycle busy_mask=0, curr_tag=0, state RUN, kill=0.
